// File: rtl/softex_tcdm_responder.sv
// TCDM responder: word-addressed scratch memory with a fixed-latency read pipeline and a credit-bounded response queue.
// Optional bank-contention grant stall enabled by defining SOFTEX_TCDM_RESP_STALL_EN.
module softex_tcdm_responder #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    tcdm_req_i,
    output logic                    tcdm_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
    input  logic                    tcdm_wen_i,
    input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
    output logic                    tcdm_r_valid_o,
    input  logic                    tcdm_r_ready_i,
    output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
    output logic [31:0]             n_reads_o,
    output logic [31:0]             n_writes_o
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int OFF_W  = (BE_W > 1) ? $clog2(BE_W) : 1;
    localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int QPTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + LATENCY + 1) + 1;

    logic                  gnt;
    logic                  credit_ok;
    logic                  accept_rd;
    logic                  accept_wr;
    logic [IDX_W-1:0]      idx;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [LATENCY-1:0]    stage_valid;
    logic [DATA_WIDTH-1:0] stage_data [LATENCY];
    logic [CNT_W-1:0]      inflight;

    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [QPTR_W-1:0]     rd_ptr;
    logic [QPTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  last_valid;
    logic [DATA_WIDTH-1:0] last_data;
    logic                  pop;
    logic                  pop_fifo;
    logic                  push_fifo;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] head_data;

    logic [31:0]           n_reads;
    logic [31:0]           n_writes;

    assign idx = tcdm_add_i[OFF_W +: IDX_W];

    // Address bits outside the word index are intentionally ignored.
    generate
        if (ADDR_WIDTH > OFF_W + IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^tcdm_add_i[ADDR_WIDTH-1:OFF_W+IDX_W];
        end
    endgenerate
    logic unused_addr_lo;
    assign unused_addr_lo = ^tcdm_add_i[OFF_W-1:0];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CNT_W'(stage_valid[i]);
        end
    end

    // Credits cover both pipeline and queue, so the queue can never overflow.
    assign credit_ok = (inflight + fifo_count) < CNT_W'(RESP_DEPTH);

`ifdef SOFTEX_TCDM_RESP_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= 16'hACE1;
        end else if (clear_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    assign gnt = rst_ni && !clear_i && credit_ok && (lfsr[1:0] != 2'b00);
`else
    assign gnt = rst_ni && !clear_i && credit_ok;
`endif

    assign accept_rd = tcdm_req_i && gnt && tcdm_wen_i;
    assign accept_wr = tcdm_req_i && gnt && !tcdm_wen_i;

    // Memory and data path carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (accept_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (tcdm_be_i[b]) begin
                    mem[idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
                end
            end
        end
        if (accept_rd) begin
            stage_data[0] <= mem[idx];
        end
        for (int i = 1; i < LATENCY; i++) begin
            stage_data[i] <= stage_data[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid <= '0;
        end else if (clear_i) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= accept_rd;
            for (int i = 1; i < LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    // The last pipeline stage acts as a fall-through entry ahead of the queue.
    assign last_valid = stage_valid[LATENCY-1];
    assign last_data  = stage_data[LATENCY-1];
    assign fifo_empty = (fifo_count == '0);
    assign r_valid    = !fifo_empty || last_valid;
    assign head_data  = fifo_empty ? last_data : fifo_mem[rd_ptr];
    assign pop        = r_valid && tcdm_r_ready_i;
    assign pop_fifo   = pop && !fifo_empty;
    assign push_fifo  = last_valid && !(pop && fifo_empty);

    function automatic logic [QPTR_W-1:0] ptr_inc(input logic [QPTR_W-1:0] p);
        return (p == QPTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_fifo) begin
            fifo_mem[wr_ptr] <= last_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (clear_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_fifo) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_fifo) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_fifo, pop_fifo})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_reads  <= '0;
            n_writes <= '0;
        end else if (clear_i) begin
            n_reads  <= '0;
            n_writes <= '0;
        end else begin
            if (accept_rd && (n_reads != 32'hFFFF_FFFF)) begin
                n_reads <= n_reads + 32'd1;
            end
            if (accept_wr && (n_writes != 32'hFFFF_FFFF)) begin
                n_writes <= n_writes + 32'd1;
            end
        end
    end

    assign tcdm_gnt_o     = gnt;
    assign tcdm_r_valid_o = r_valid;
    assign tcdm_r_data_o  = r_valid ? head_data : '0;
    assign n_reads_o      = n_reads;
    assign n_writes_o     = n_writes;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_fifo && !pop_fifo && (fifo_count == CNT_W'(RESP_DEPTH))));

    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid && !tcdm_r_ready_i && !clear_i) |=> $stable(tcdm_r_data_o));
`endif

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Bench for softex_tcdm_responder: transaction-level memory/queue model checked every cycle plus directed literal checks.
module tb_softex_tcdm_responder;

    localparam int DW  = 128;
    localparam int AW  = 32;
    localparam int MW  = 1024;
    localparam int LAT = 1;
    localparam int RD  = 4;
    localparam int BW  = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          req;
    logic          gnt;
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic          r_valid;
    logic          r_ready;
    logic [DW-1:0] r_data;
    logic [31:0]   n_reads;
    logic [31:0]   n_writes;

    softex_tcdm_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW), .LATENCY(LAT), .RESP_DEPTH(RD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
        .tcdm_be_i(be), .tcdm_data_i(wdata),
        .tcdm_r_valid_o(r_valid), .tcdm_r_ready_i(r_ready), .tcdm_r_data_o(r_data),
        .n_reads_o(n_reads), .n_writes_o(n_writes)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: memory image, queue of outstanding reads in request order, counters.
    typedef struct {
        logic [DW-1:0] data;
        logic          known;
        int            cyc;
    } resp_t;

    resp_t         q[$];
    logic [DW-1:0] mmem [int];
    int            cyc      = 0;
    int            m_reads  = 0;
    int            m_writes = 0;
    bit            sb_en    = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            logic exp_gnt;
            logic acc;
            logic exp_rv;
            int   widx;
            exp_gnt = !clear && (q.size() < RD);
`ifdef SOFTEX_TCDM_RESP_STALL_EN
            check("gnt_within_credit", gnt && !exp_gnt, 1'b0);
            acc = req && gnt;
`else
            check("gnt", gnt, exp_gnt);
            acc = req && exp_gnt;
`endif
            exp_rv = (q.size() > 0) && (q[0].cyc + LAT <= cyc);
            check("r_valid", r_valid, exp_rv);
            if (exp_rv && q[0].known) check("r_data", r_data, q[0].data);
            check("n_reads", n_reads, DW'(m_reads));
            check("n_writes", n_writes, DW'(m_writes));
            if (exp_rv && r_ready) void'(q.pop_front());
            if (clear) begin
                q.delete();
                m_reads  = 0;
                m_writes = 0;
            end else if (acc) begin
                widx = int'((add >> 4) % MW);
                if (wen) begin
                    resp_t e;
                    e.data  = mmem.exists(widx) ? mmem[widx] : 'x;
                    e.known = !$isunknown(e.data);
                    e.cyc   = cyc;
                    q.push_back(e);
                    m_reads++;
                    $display("txn cyc=%0d READ  addr=%h word=%0d", cyc, add, widx);
                end else begin
                    logic [DW-1:0] w;
                    w = mmem.exists(widx) ? mmem[widx] : 'x;
                    for (int b = 0; b < BW; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                    mmem[widx] = w;
                    m_writes++;
                    $display("txn cyc=%0d WRITE addr=%h word=%0d be=%h data=%h", cyc, add, widx, be, wdata);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] e);
        int n;
        req = 1'b1; wen = w; add = a; wdata = d; be = e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt && n < 200);
        if (!gnt) begin
            vectors++; errors++;
            $display("FAIL grant_timeout: got no gnt for addr %h, required gnt within 200 cycles", a);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int n;
        issue(1'b1, a, '0, '0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r_valid && n < 50);
        check(name, r_data, exp);
        @(posedge clk); #1;
    endtask

    localparam logic [DW-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] D3 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    logic [AW-1:0] addrs [9] = '{32'h10, 32'h20, 32'h50, 32'h200, 32'h210,
                                 32'h220, 32'h230, 32'h240, 32'h250};

    initial begin
        int grants;
        int k;
        logic g;

        rst_n = 1'b0; clear = 1'b0; req = 1'b1; wen = 1'b1; add = '0;
        be = '0; wdata = '0; r_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_gnt", gnt, 1'b0);
        check("reset_r_valid", r_valid, 1'b0);
        check("reset_r_data", r_data, '0);
        check("reset_n_reads", n_reads, '0);
        check("reset_n_writes", n_writes, '0);
        @(posedge clk); #1;
        req = 1'b0; rst_n = 1'b1; sb_en = 1;

        // Basic write then read, LATENCY=1 -> r_valid the cycle after accept.
        issue(1'b0, 32'h10, D1, '1);
        issue(1'b1, 32'h10, '0, '0);
        @(negedge clk);
        check("lat1_r_valid", r_valid, 1'b1);
        check("lat1_r_data", r_data, D1);
        @(posedge clk); #1;
        @(negedge clk);
        check("basic_n_writes", n_writes, 128'd1);
        check("basic_n_reads", n_reads, 128'd1);
        @(posedge clk); #1;

        // Byte-enable merge.
        issue(1'b0, 32'h20, '1, '1);
        issue(1'b0, 32'h20, '0, 16'h000F);
        read_expect("be_merge", 32'h20, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);

        // Address wrap and ignored upper bits.
        issue(1'b0, 32'h50, D3, '1);
        read_expect("wrap_1029", (1024 + 5) * 16, D3);
        read_expect("wrap_upper", 32'h8000_0050, D3);

        // Backpressure: 6 reads with r_ready low.
        for (int i = 0; i < 6; i++) issue(1'b0, 32'h200 + 32'(i * 16), {4{32'(100 + i)}}, '1);
        r_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) issue(1'b1, 32'h200 + 32'(i * 16), '0, '0);
            end
            begin
                grants = 0;
                repeat (30) begin
                    @(negedge clk);
                    if (req && gnt) grants++;
                end
                check("bp_grants", 128'(grants), 128'd4);
                check("bp_gnt_low", gnt, 1'b0);
                @(posedge clk); #1;
                r_ready = 1'b1;
                @(negedge clk);
                check("bp_first_resp", r_data, {4{32'd100}});
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // Soft clear with 3 reads outstanding.
        r_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b1, 32'h10, '0, '0);
        clear = 1'b1; req = 1'b1; wen = 1'b1; add = 32'h10;
        @(negedge clk);
        check("clear_gnt", gnt, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0; req = 1'b0;
        @(negedge clk);
        check("clear_r_valid", r_valid, 1'b0);
        check("clear_n_reads", n_reads, '0);
        check("clear_n_writes", n_writes, '0);
        @(posedge clk); #1;
        r_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        read_expect("after_clear", 32'h10, D1);

        // Streaming reads with req held high for 1000 cycles.
        grants = 0; k = 0;
        req = 1'b1; wen = 1'b1; add = addrs[0];
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            g = gnt;
            if (g) grants++;
            @(posedge clk); #1;
            if (g) begin
                k = (k + 1) % 9;
                add = addrs[k];
            end
        end
        req = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("stream_n_reads", n_reads, 128'(1 + grants));
        check("stream_drained", r_valid, 1'b0);
`ifdef SOFTEX_TCDM_RESP_STALL_EN
        check("stream_stalled", 128'(grants < 1000), 128'd1);
`else
        check("stream_grants", 128'(grants), 128'd1000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
